// File: rtl/mr_if_pkg.sv
// mr_if_pkg: shared fetch-stage configuration.
// Widths, instruction alignment and the default reset PC.
package mr_if_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          IMAXLEN_DEF  = 32;
  localparam int          IALIGN       = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/mr_if_fifo.sv
// mr_if_fifo: small synchronous FIFO with flush.
// A push into a full FIFO is accepted only alongside a pop.
module mr_if_fifo
  import mr_if_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mr_if.sv
// mr_if: instruction fetch stage feeding decode.
// Credit-limited fetch into an in-order buffer; redirects drop in-flight data.
module mr_if
  import mr_if_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter int               IMAXLEN  = IMAXLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF,
  parameter int               DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [IMAXLEN-1:0] imem_rsp_data,
  output logic [IMAXLEN-1:0] inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               jmp_valid,
  input  logic [XLEN-1:0]    jmp_target
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = IMAXLEN + XLEN;

  typedef enum logic {ST_RESET, ST_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              run;
  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     out_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     ibuf_count;
  logic [CW:0]       credit;
  logic              accept;
  logic              rsp_fire;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   rsp_pc;
  logic [BW-1:0]     head;
  logic              ibuf_empty;
  logic              ibuf_full;
  logic              pq_empty;
  logic              pq_full;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    unique case (state)
      ST_RESET: state_nxt = ST_RUN;
      ST_RUN:   run = 1'b1;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // Buffered plus in-flight entries never exceed DEPTH.
  assign credit         = {1'b0, outstanding} + {1'b0, ibuf_count};
  assign imem_req_valid = run && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_fire       = run && imem_rsp_valid && !pq_empty;
  assign out_nxt        = outstanding + CW'(accept) - CW'(rsp_fire);

  assign push = rsp_fire && (drop == '0) && !jmp_valid;
  assign pop  = inst_valid && inst_ready && !jmp_valid;

  assign inst_valid = !ibuf_empty;
  assign inst       = inst_valid ? head[BW-1:XLEN] : '0;
  assign inst_pc    = inst_valid ? head[XLEN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (jmp_valid) begin
      fetch_pc <= {jmp_target[XLEN-1:2], 2'b00};
      drop     <= out_nxt;
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(IALIGN);
      if (rsp_fire && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  mr_if_fifo #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (jmp_valid),
    .din   ({imem_rsp_data, rsp_pc}),
    .dout  (head),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_count)
  );

  // Its occupancy is the outstanding-request count.
  mr_if_fifo #(
    .W     (XLEN),
    .DEPTH (DEPTH)
  ) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (rsp_fire),
    .flush (1'b0),
    .din   (fetch_pc),
    .dout  (rsp_pc),
    .full  (pq_full),
    .empty (pq_empty),
    .count (outstanding)
  );

  a_rsp_credit: assert property (@(posedge clk) disable iff (!rst_n)
    (run && imem_rsp_valid) |-> !pq_empty);
  a_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (!ibuf_full || pop));
  a_pq_full: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (!pq_full || rsp_fire));
  a_drop: assert property (@(posedge clk) disable iff (!rst_n)
    drop <= outstanding);
  a_jmp_align: assert property (@(posedge clk) disable iff (!rst_n)
    jmp_valid |-> (jmp_target[1:0] == 2'b00));

endmodule

// File: tb/tb_mr_if.sv
// tb_mr_if: fetch-stage bench with memory model and in-order scoreboard.
// Directed sequences, a redirect table and a random phase.
module tb_mr_if;

  localparam int          XLEN     = 32;
  localparam int          IMAXLEN  = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        jmp_valid;
  logic [31:0] jmp_target;

  always #5 clk = ~clk;

  mr_if #(
    .XLEN     (XLEN),
    .IMAXLEN  (IMAXLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .jmp_valid      (jmp_valid),
    .jmp_target     (jmp_target)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] sb[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] del_pc[$];
  int          del_cyc[$];
  logic [31:0] exp_pc = RESET_PC;
  int          m_out = 0;
  int          m_drop = 0;
  logic        jmp_seen = 1'b0;
  logic        hold_q = 1'b0;
  logic [31:0] hold_addr = '0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    acc_cyc.delete();
    del_pc.delete();
    del_cyc.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always begin : mon
    logic acc;
    logic rsp;
    logic jmp;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      sb.delete();
      pend_addr.delete();
      pend_due.delete();
      exp_pc   = RESET_PC;
      m_out    = 0;
      m_drop   = 0;
      jmp_seen = 1'b0;
      hold_q   = 1'b0;
    end else begin
      if (jmp_seen) begin
        chk("drop_after_jmp", 32'(dut.drop), 32'(m_drop));
        chk("outst_after_jmp", 32'(dut.outstanding), 32'(m_out));
      end
      if (hold_q) begin
        chk("req_held_valid", 32'(imem_req_valid), 32'd1);
        chk("req_held_addr", imem_req_addr, hold_addr);
      end
      acc = imem_req_valid && imem_req_ready;
      rsp = imem_rsp_valid;
      jmp = jmp_valid;
      if (inst_valid && inst_ready && !jmp) begin
        chk("deliver_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          chk("inst_pc", inst_pc, sb[0]);
          chk("inst", inst, memdata(sb[0]));
          void'(sb.pop_front());
        end
        del_pc.push_back(inst_pc);
        del_cyc.push_back(cyc + 1);
      end
      if (acc) begin
        chk("req_addr", imem_req_addr, exp_pc);
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
        sb.push_back(exp_pc);
        acc_addr.push_back(imem_req_addr);
        acc_cyc.push_back(cyc + 1);
        exp_pc = exp_pc + 32'd4;
      end
      m_out = m_out + int'(acc) - int'(rsp);
      if (jmp) begin
        sb.delete();
        exp_pc = {jmp_target[31:2], 2'b00};
        m_drop = m_out;
      end else if (rsp && m_drop > 0) begin
        m_drop--;
      end
      jmp_seen  = jmp;
      hold_q    = imem_req_valid && !imem_req_ready && !jmp;
      hold_addr = imem_req_addr;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memdata(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  typedef struct {
    int          lat;
    logic [31:0] tgt;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
  } jrow_t;

  jrow_t rows[4];

  initial begin
    int t;
    int rel;
    rows[0] = '{3, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    rows[1] = '{2, 32'hffff_fff8, 32'hffff_fff8, 32'hffff_fffc, 32'h0000_0000};
    rows[2] = '{1, 32'hffff_fffc, 32'hffff_fffc, 32'h0000_0000, 32'h0000_0004};
    rows[3] = '{2, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048};

    rst_n          = 1'b0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    jmp_valid      = 1'b0;
    jmp_target     = '0;
    cycles(2);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);

    clear_logs();
    rel   = cyc;
    rst_n = 1'b1;
    cycles(10);
    chk("fill_acc_count", 32'(acc_addr.size() >= 3), 32'd1);
    chk("fill_a0", acc_addr[0], 32'h0);
    chk("fill_a1", acc_addr[1], 32'h4);
    chk("fill_a2", acc_addr[2], 32'h8);
    chk("fill_acc0_cyc", 32'(acc_cyc[0] - rel), 32'd2);
    chk("fill_acc1_cyc", 32'(acc_cyc[1] - rel), 32'd3);
    chk("fill_del0_cyc", 32'(del_cyc[0] - rel), 32'd4);
    chk("fill_pc0", del_pc[0], 32'h0);
    chk("fill_pc1", del_pc[1], 32'h4);
    chk("fill_pc2", del_pc[2], 32'h8);

    inst_ready = 1'b0;
    cycles(10);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    chk("stall_buf_count", 32'(dut.u_ibuf.count), 32'(DEPTH));
    chk("stall_outst", 32'(dut.outstanding), 32'd0);
    clear_logs();
    inst_ready = 1'b1;
    cycles(8);
    chk("drain_b2b", 32'(del_cyc[1] - del_cyc[0]), 32'd1);
    chk("drain_contig", del_pc[1] - del_pc[0], 32'd4);

    inst_ready = 1'b0;
    cycles(6);
    rst_n = 1'b0;
    cycles(1);
    chk("rstfull_inst_valid", 32'(inst_valid), 32'd0);
    chk("rstfull_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rstfull_req_addr", imem_req_addr, RESET_PC);
    clear_logs();
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    cycles(8);
    chk("rstfull_restart_addr", acc_addr[0], RESET_PC);
    chk("rstfull_restart_pc", del_pc[0], RESET_PC);

    mem_lat = 2;
    cycles(6);
    t = 0;
    @(negedge clk);
    #1;
    while (!imem_rsp_valid && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("late_rsp_present", 32'(imem_rsp_valid), 32'd1);
    rst_n = 1'b0;
    cycles(1);
    chk("late_inst_valid", 32'(inst_valid), 32'd0);
    clear_logs();
    rst_n = 1'b1;
    cycles(10);
    chk("late_restart_pc", del_pc[0], RESET_PC);

    foreach (rows[i]) begin
      mem_lat    = rows[i].lat;
      inst_ready = 1'b1;
      cycles(6);
      jmp_valid  = 1'b1;
      jmp_target = rows[i].tgt;
      cycles(1);
      jmp_valid = 1'b0;
      clear_logs();
      cycles(15);
      chk("jmp_a0", acc_addr[0], rows[i].a0);
      chk("jmp_a1", acc_addr[1], rows[i].a1);
      chk("jmp_a2", acc_addr[2], rows[i].a2);
      chk("jmp_first_pc", del_pc[0], rows[i].tgt);
    end

    mem_lat = 1;
    cycles(4);
    t = 0;
    @(negedge clk);
    #1;
    while (!(imem_req_valid && imem_req_ready && imem_rsp_valid) && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("same_cycle_found",
        32'(imem_req_valid && imem_req_ready && imem_rsp_valid), 32'd1);
    jmp_valid  = 1'b1;
    jmp_target = 32'h0000_0200;
    @(posedge clk);
    #1;
    chk("drop_same_cycle", 32'(dut.drop), 32'd1);
    #1;
    jmp_valid = 1'b0;
    clear_logs();
    cycles(10);
    chk("same_cycle_first_pc", del_pc[0], 32'h0000_0200);

    for (int k = 0; k < 80; k++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = ($urandom_range(0, 3) != 0);
      mem_lat        = 1 + int'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) begin
        jmp_valid  = 1'b1;
        jmp_target = 32'($urandom_range(0, 1023)) << 2;
      end else begin
        jmp_valid = 1'b0;
      end
      cycles(1);
    end
    jmp_valid = 1'b0;

    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    cycles(12);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    chk("end_inst_valid", 32'(inst_valid), 32'd0);
    chk("end_outst", 32'(dut.outstanding), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
